ifetch_pq: RTL and testbench

Parametrised instruction-fetch unit with a prefetch queue. It is the successor to the single-slot fetch stage in the IF→ID→EX core. It drives the synchronous instruction memory every cycle it has credit, captures returned words with their addresses in a DEPTH-entry queue, and presents the queue head to decode under a valid/stall handshake. A taken branch from EX flushes the queue and kills the in-flight read.

---
 rtl/ifetch_pq_pkg.sv | 14 +
 rtl/pq_fifo.sv | 66 ++++++
 rtl/ifetch_pq.sv | 89 ++++++++
 tb/tb_ifetch_pq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pq_pkg.sv
// Shared defaults for the prefetching instruction-fetch unit and its queue.
package ifetch_pq_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int WORD_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;
    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

    // Occupancy counters need one bit more than the pointers to represent "full".
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pq_fifo.sv
// Generic synchronous FIFO with flush, combinational head read and occupancy count.
module pq_fifo
    import ifetch_pq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [cnt_w(DEPTH)-1:0]  count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // A pop frees the head slot, so a push into a full queue is legal alongside it.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= DEPTH_C);
        end
    end

endmodule

// File: rtl/ifetch_pq.sv
// Instruction fetch with a prefetch queue: credit-based memory requests, FIFO
// capture of returned words and a valid/stall head handshake; branches flush.
module ifetch_pq
    import ifetch_pq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        imem_addr_o,
    input  logic [WORD_W-1:0]        imem_q_i,
    input  logic [ADDR_W-1:0]        imem_ao_i,
    input  logic                     branch_i,
    input  logic [ADDR_W-1:0]        baddr_i,
    input  logic                     stall_i,
    output logic                     v_o,
    output logic [WORD_W-1:0]        inst_o,
    output logic [ADDR_W-1:0]        origaddr_o,
    output logic [cnt_w(DEPTH)-1:0]  count_o
);

    localparam int CW = cnt_w(DEPTH);
    localparam int OW = CW + 1;

    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic                     req_v_q, req_v_d;
    logic                     push, pop, issue, fifo_full, fifo_empty;
    logic [OW-1:0]            occ;
    logic [WORD_W+ADDR_W-1:0] head;

    assign imem_addr_o = pc_q;
    assign v_o         = ~fifo_empty;
    assign pop         = v_o & ~stall_i & ~branch_i;
    assign push        = req_v_q & ~branch_i;

    // Slots committed after this cycle: stored entries plus the read in flight.
    assign occ   = {1'b0, count_o} + OW'(req_v_q) - OW'(pop);
    assign issue = ~branch_i & (occ < OW'(DEPTH));

    always_comb begin
        pc_d    = pc_q;
        req_v_d = issue;
        if (branch_i) begin
            pc_d = baddr_i;
        end else if (issue) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            req_v_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            req_v_q <= req_v_d;
        end
    end

    pq_fifo #(
        .WIDTH (WORD_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (branch_i),
        .wdata_i ({imem_q_i, imem_ao_i}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign inst_o     = head[WORD_W+ADDR_W-1:ADDR_W];
    assign origaddr_o = head[ADDR_W-1:0];

    // Credit logic must never let a capture land in a full queue without a pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_full && !pop));
        end
    end

endmodule

// File: tb/tb_ifetch_pq.sv
// Bench for ifetch_pq: directed vector table, hand sequences for multi-cycle
// corners, then random stimulus against a queue-based reference model.
module tb_ifetch_pq;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr, imem_ao, baddr_i, origaddr;
    logic [31:0] imem_q, inst;
    logic        branch_i, stall_i, v;
    logic [2:0]  count;

    logic [15:0] w_addr, w_ao, w_orig;
    logic [31:0] w_q, w_inst;
    logic        w_v;
    logic [2:0]  w_count;

    int total = 0;
    int bad   = 0;

    // Reference model state: expected queue contents, read in flight, PC.
    logic [15:0] mq[$];
    logic        m_req;
    logic [15:0] m_reqaddr;
    logic [15:0] m_pc;

    ifetch_pq #(.ADDR_W(16), .WORD_W(32), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .imem_addr_o(imem_addr), .imem_q_i(imem_q),
        .imem_ao_i(imem_ao), .branch_i(branch_i), .baddr_i(baddr_i),
        .stall_i(stall_i), .v_o(v), .inst_o(inst), .origaddr_o(origaddr),
        .count_o(count)
    );

    ifetch_pq #(.ADDR_W(16), .WORD_W(32), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_wrap (
        .clk(clk), .rst(rst), .imem_addr_o(w_addr), .imem_q_i(w_q),
        .imem_ao_i(w_ao), .branch_i(branch_i), .baddr_i(baddr_i),
        .stall_i(stall_i), .v_o(w_v), .inst_o(w_inst), .origaddr_o(w_orig),
        .count_o(w_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'h1000_0000 + {16'h0000, a};
    endfunction

    // Synchronous instruction memories: data and echoed address one cycle later.
    always @(posedge clk) begin
        imem_q  <= mem_word(imem_addr);
        imem_ao <= imem_addr;
        w_q     <= mem_word(w_addr);
        w_ao    <= w_addr;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("model_v", {31'd0, v}, {31'd0, mq.size() > 0});
        chk("model_count", {29'd0, count}, mq.size());
        chk("model_pc", {16'd0, imem_addr}, {16'd0, m_pc});
        if (mq.size() > 0) begin
            chk("model_orig", {16'd0, origaddr}, {16'd0, mq[0]});
            chk("model_inst", inst, mem_word(mq[0]));
        end
    endtask

    task automatic model_step(input logic r, input logic br, input logic [15:0] ba,
                              input logic st);
        bit pop;
        int occ;
        if (r) begin
            mq.delete();
            m_req = 1'b0;
            m_pc  = 16'h0000;
        end else if (br) begin
            mq.delete();
            m_req = 1'b0;
            m_pc  = ba;
        end else begin
            pop = (mq.size() > 0) && !st;
            occ = mq.size() + int'(m_req) - int'(pop);
            if (pop) void'(mq.pop_front());
            if (m_req) mq.push_back(m_reqaddr);
            if (occ < DEPTH) begin
                m_req     = 1'b1;
                m_reqaddr = m_pc;
                m_pc      = m_pc + 16'd1;
            end else begin
                m_req = 1'b0;
            end
        end
    endtask

    task automatic start(input logic r, input logic st, input logic br, input logic [15:0] ba);
        rst = r; stall_i = st; branch_i = br; baddr_i = ba;
        @(negedge clk);
        model_check();
    endtask

    task automatic finish_cyc();
        @(posedge clk);
        model_step(rst, branch_i, baddr_i, stall_i);
        #1;
    endtask

    task automatic cyc(input logic r, input logic st, input logic br, input logic [15:0] ba);
        start(r, st, br, ba);
        finish_cyc();
    endtask

    typedef struct {
        logic        r, st, br;
        logic [15:0] ba;
        logic        ev;
        int          ecnt;
        logic [15:0] epc, eorig, eworig;
    } vec_t;

    vec_t tbl[12];
    bit   found;

    initial begin
        // r st br baddr | v cnt pc orig wrap_orig
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 16'h0001, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0002, 16'h0000, 16'hFFFE};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0003, 16'h0001, 16'hFFFF};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0004, 16'h0002, 16'h0000};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1, 16'h0005, 16'h0003, 16'h0001};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 2, 16'h0006, 16'h0003, 16'h0001};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 16'h0040, 16'h0000, 16'h0000};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 16'h0041, 16'h0000, 16'h0000};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0042, 16'h0040, 16'h0040};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0043, 16'h0041, 16'h0041};

        rst = 1'b1; stall_i = 1'b0; branch_i = 1'b0; baddr_i = 16'h0000;
        m_req = 1'b0; m_reqaddr = 16'h0000; m_pc = 16'h0000;
        @(posedge clk);
        model_step(1'b1, 1'b0, 16'h0000, 1'b0);
        #1;

        // Reset, run-in, stall, branch flush, and the wrap-around instance alongside.
        for (int i = 0; i < 12; i++) begin
            start(tbl[i].r, tbl[i].st, tbl[i].br, tbl[i].ba);
            chk($sformatf("vec%0d_v", i), {31'd0, v}, {31'd0, tbl[i].ev});
            chk($sformatf("vec%0d_count", i), {29'd0, count}, tbl[i].ecnt);
            chk($sformatf("vec%0d_pc", i), {16'd0, imem_addr}, {16'd0, tbl[i].epc});
            chk($sformatf("vec%0d_wrap_v", i), {31'd0, w_v}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_orig", i), {16'd0, origaddr}, {16'd0, tbl[i].eorig});
                chk($sformatf("vec%0d_inst", i), inst, mem_word(tbl[i].eorig));
                chk($sformatf("vec%0d_wrap_orig", i), {16'd0, w_orig}, {16'd0, tbl[i].eworig});
                chk($sformatf("vec%0d_wrap_inst", i), w_inst, mem_word(tbl[i].eworig));
            end
            $display("vec %0d: rst=%b st=%b br=%b v=%b cnt=%0d pc=%h orig=%h",
                     i, tbl[i].r, tbl[i].st, tbl[i].br, v, count, imem_addr, origaddr);
            finish_cyc();
        end

        // Stall fill from the first valid head, then release.
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        start(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("fill_count", {29'd0, count}, 32'd4);
        chk("fill_pc", {16'd0, imem_addr}, 32'd4);
        chk("fill_head", {16'd0, origaddr}, 32'd0);
        $display("stall fill: cnt=%0d pc=%h head=%h", count, imem_addr, origaddr);
        finish_cyc();
        for (int k = 0; k < 8; k++) begin
            start(1'b0, 1'b0, 1'b0, 16'h0000);
            chk($sformatf("drain%0d_v", k), {31'd0, v}, 32'd1);
            chk($sformatf("drain%0d_orig", k), {16'd0, origaddr}, k);
            $display("drain %0d: v=%b orig=%h", k, v, origaddr);
            finish_cyc();
        end

        // Back-to-back branches while stalled: only the last target streams.
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1, 16'h0100);
        cyc(1'b0, 1'b1, 1'b1, 16'h0200);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            start(1'b0, 1'b0, 1'b0, 16'h0000);
            if (v === 1'b1) begin
                found = 1'b1;
                chk("br2_first", {16'd0, origaddr}, 32'h0200);
            end
            finish_cyc();
        end
        chk("br2_seen", {31'd0, found}, 32'd1);
        start(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("br2_next", {16'd0, origaddr}, 32'h0201);
        $display("branch pair: head=%h", origaddr);
        finish_cyc();

        // Reset with entries queued and a read in flight.
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        start(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_v", {31'd0, v}, 32'd0);
        chk("rst_pc", {16'd0, imem_addr}, 32'd0);
        finish_cyc();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            start(1'b0, 1'b0, 1'b0, 16'h0000);
            if (v === 1'b1) begin
                found = 1'b1;
                chk("rst_restart", {16'd0, origaddr}, 32'd0);
            end
            finish_cyc();
        end
        chk("rst_seen", {31'd0, found}, 32'd1);
        $display("mid reset: restart head=%h", origaddr);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 19) == 0, 16'($urandom));
        end
        $display("random: 3000 cycles");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
